// File: rtl/gsim_pkg.sv
// +--------------------------------------------------------------------+
// | gsim_pkg -- shared drain FSM states and default frame geometry      |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package gsim_pkg;

  localparam int C_BIT_WIDTH  = 32;
  localparam int C_N_ELEM     = 16;
  localparam int C_FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/x_drain_fifo.sv
// +--------------------------------------------------------------------+
// | x_drain_fifo -- circular solution-word buffer, registered head     |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module x_drain_fifo #(
  parameter int BIT_WIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_clr,
  input  logic                 i_push,
  input  logic [BIT_WIDTH-1:0] i_data,
  input  logic                 i_pop,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [BIT_WIDTH-1:0] o_head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BIT_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr <= (r_wr_ptr == AW'(DEPTH-1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == AW'(DEPTH-1)) ? '0 : r_rd_ptr + AW'(1);
      end
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/x_drain.sv
// +--------------------------------------------------------------------+
// | x_drain -- frames N_ELEM solver words through a small FIFO; the    |
// | optional X_DRAIN_STATS_EN build adds a stall_cnt output. rev 1.0   |
// +--------------------------------------------------------------------+
`default_nettype none

module x_drain
  import gsim_pkg::*;
#(
  parameter int BIT_WIDTH  = C_BIT_WIDTH,
  parameter int N_ELEM     = C_N_ELEM,
  parameter int FIFO_DEPTH = C_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BIT_WIDTH-1:0]      in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BIT_WIDTH-1:0]      out_data,
  output logic [$clog2(N_ELEM)-1:0] out_idx,
  output logic                      out_last,
  output logic                      busy,
`ifdef X_DRAIN_STATS_EN
  output logic [15:0]               stall_cnt,
`endif
  output logic                      done
);

  localparam int IW = $clog2(N_ELEM);
  localparam int CW = $clog2(N_ELEM + 1);

  state_t        r_state;
  logic [CW-1:0] r_in_cnt;
  logic [CW-1:0] r_out_cnt;
  logic          r_busy;
  logic          r_done;

  logic                 w_full;
  logic                 w_empty;
  logic [BIT_WIDTH-1:0] w_head;
  logic                 w_in_xfer;
  logic                 w_out_xfer;
  logic                 w_start_frame;

  assign in_ready      = (r_state == S_RUN) && !w_full && (r_in_cnt < CW'(N_ELEM));
  assign out_valid     = !w_empty;
  assign out_data      = w_head;
  assign out_idx       = r_out_cnt[IW-1:0];
  assign out_last      = out_valid && (r_out_cnt == CW'(N_ELEM-1));
  assign busy          = r_busy;
  assign done          = r_done;
  assign w_in_xfer     = in_valid && in_ready;
  assign w_out_xfer    = out_valid && out_ready;
  assign w_start_frame = (r_state == S_IDLE) && start;

  x_drain_fifo #(
    .BIT_WIDTH (BIT_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_start_frame),
    .i_push  (w_in_xfer),
    .i_data  (in_data),
    .i_pop   (w_out_xfer),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state   <= S_RUN;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_busy    <= 1'b1;
          end
        end
        S_RUN: begin
          if (w_in_xfer) r_in_cnt <= r_in_cnt + CW'(1);
          if (w_out_xfer) begin
            r_out_cnt <= r_out_cnt + CW'(1);
            if (r_out_cnt == CW'(N_ELEM-1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef X_DRAIN_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_start_frame) begin
      r_stall_cnt <= '0;
    end else if ((r_state == S_RUN) && out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_x_drain.sv
// +--------------------------------------------------------------------+
// | tb_x_drain -- directed self-checking bench for x_drain             |
// | rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_x_drain;

  localparam int NE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;
`ifdef X_DRAIN_STATS_EN
  logic [15:0] stall_cnt;
`endif

  always #5 clk = ~clk;

  x_drain #(
    .BIT_WIDTH  (32),
    .N_ELEM     (NE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
`ifdef X_DRAIN_STATS_EN
    .stall_cnt (stall_cnt),
`endif
    .done      (done)
  );

  int          passes = 0;
  int          total  = 0;
  logic [31:0] exp_q[$];
  int          exp_idx;
  int          nout;
  int          nd;
  bit          acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: drive at the falling edge, score what transfers at the next rising edge.
  task automatic drive_cycle(input bit v, input logic [31:0] d, input bit r);
    logic [31:0] e;
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    acc = v && (in_ready === 1'b1);
    if ((out_valid === 1'b1) && r) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("out_data", out_data, e);
      check("out_idx", 32'(out_idx), exp_idx);
      check("out_last", 32'(out_last), (exp_idx == NE-1) ? 32'd1 : 32'd0);
      exp_idx++;
      nout++;
    end
    if (acc) exp_q.push_back(d);
  endtask

  task automatic do_start();
    @(negedge clk);
    start     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_run", 32'(busy), 1);
    check("in_ready_run", 32'(in_ready), 1);
    exp_q.delete();
    exp_idx = 0;
    nout    = 0;
  endtask

  task automatic finish_frame(input int last);
    int guard;
    guard = 0;
    while (nout < NE && guard < 80) begin
      drive_cycle(nd <= last, nd, 1'b1);
      if (acc) nd++;
      guard++;
    end
    check("frame_outputs", nout, NE);
    drive_cycle(1'b0, 32'd0, 1'b1);
    check("done_pulse_hi", 32'(done), 1);
    check("busy_done", 32'(busy), 0);
    drive_cycle(1'b0, 32'd0, 1'b0);
    check("done_pulse_lo", 32'(done), 0);
    check("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc_cnt;
    int done_cnt;

    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    exp_idx   = 0;
    nout      = 0;
    nd        = 1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_idx", 32'(out_idx), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming frame: words 1..16 with downstream always ready.
    do_start();
    nd = 1;
    for (int i = 0; i < NE; i++) begin
      drive_cycle(1'b1, nd, 1'b1);
      check("stream_accept", 32'(acc), 1);
      if (acc) nd++;
    end
    finish_frame(NE);

    // Downstream stalled for 10 cycles: FIFO fills after 4 words, head holds 1.
    do_start();
    nd = 1;
    for (int i = 0; i < 10; i++) begin
      drive_cycle(1'b1, nd, 1'b0);
      if (acc) nd++;
      if (i >= 1) check("stall_head", out_data, 1);
      if (i == 4) check("stall_in_ready", 32'(in_ready), 0);
    end
    check("stall_accepts", nd - 1, 4);
    finish_frame(NE);

    // Full FIFO with a pop in the same cycle: no push then, push next cycle.
    do_start();
    nd = 1;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, nd, 1'b0);
      if (acc) nd++;
    end
    drive_cycle(1'b1, nd, 1'b1);
    check("full_no_push", 32'(acc), 0);
    if (acc) nd++;
    drive_cycle(1'b1, nd, 1'b1);
    check("push_after_full", 32'(acc), 1);
    if (acc) nd++;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, nd, 1'b1);
      check("steady_in_ready", 32'(acc), 1);
      if (acc) nd++;
    end
    finish_frame(NE);

    // Reset after 7 accepted words, then a fresh frame of 101..116.
    do_start();
    nd = 1;
    for (int g = 0; g < 20 && nd <= 7; g++) begin
      drive_cycle(1'b1, nd, 1'b1);
      if (acc) nd++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_out_idx", 32'(out_idx), 0);
    check("mid_rst_out_last", 32'(out_last), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("post_rst_no_output", 32'(out_valid), 0);
    do_start();
    nd = 101;
    drive_cycle(1'b1, nd, 1'b1);
    if (acc) nd++;
    drive_cycle(1'b1, nd, 1'b1);
    check("fresh_head_data", out_data, 101);
    check("fresh_head_idx", 32'(out_idx), 0);
    if (acc) nd++;
    finish_frame(116);

    // start held during RUN, 20 words offered: exactly 16 taken, one done.
    do_start();
    nd       = 1;
    acc_cnt  = 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      start = (i >= 3 && i <= 8);
      drive_cycle(1'b1, nd, 1'b1);
      if (acc) begin
        nd++;
        acc_cnt++;
      end
      if (done === 1'b1) done_cnt++;
    end
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b0, 32'd0, 1'b1);
      if (done === 1'b1) done_cnt++;
    end
    check("surplus_accepts", acc_cnt, 16);
    check("surplus_outputs", nout, NE);
    check("surplus_done_count", done_cnt, 1);
    check("surplus_idle", 32'(busy), 0);

`ifdef X_DRAIN_STATS_EN
    // Five stalled RUN cycles, then the counter clears on the next start.
    do_start();
    nd = 1;
    drive_cycle(1'b1, nd, 1'b1);
    if (acc) nd++;
    for (int i = 0; i < 5; i++) drive_cycle(1'b0, 32'd0, 1'b0);
    finish_frame(NE);
    check("stall_cnt_five", 32'(stall_cnt), 5);
    do_start();
    check("stall_cnt_cleared", 32'(stall_cnt), 0);
`endif

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/x_drain.md
X_DRAIN -- requirements
Module: x_drain

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, meaning solution word width.
REQ-002 SHALL have parameter N_ELEM, default 16, meaning solution words per frame.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning internal buffer entries (power of two).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  begin a frame; sampled only in IDLE.
REQ-007 SHALL have port in_valid  input  1  solver presents a solution word.
REQ-008 SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-009 SHALL have port in_data  input  BIT_WIDTH  solution word from the shift-register outputs.
REQ-010 SHALL have port out_valid  output  1  downstream word available.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the word.
REQ-012 SHALL have port out_data  output  BIT_WIDTH  buffered solution word.
REQ-013 SHALL have port out_idx  output  $clog2(N_ELEM)  element index of out_data, 0..N_ELEM-1.
REQ-014 SHALL have port out_last  output  1  high with the element at index N_ELEM-1.
REQ-015 SHALL have port busy  output  1  high in RUN.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last word is handed downstream.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 SHALL go IDLE->RUN on start=1; start SHALL be ignored in RUN and DONE.
REQ-019 SHALL go RUN->DONE in the cycle after the N_ELEM-th output transfer (out_valid&&out_ready), and DONE->IDLE unconditionally after one cycle.
REQ-020 SHALL define an input transfer as in_valid&&in_ready and an output transfer as out_valid&&out_ready.
REQ-021 SHALL drive in_ready = (state==RUN) && !fifo_full && (in_cnt < N_ELEM), combinationally from registered state only.
REQ-022 SHALL write each accepted word into a FIFO_DEPTH circular buffer; write and read pointers SHALL wrap modulo FIFO_DEPTH.
REQ-023 SHALL provide one-cycle latency: a word accepted in cycle t is first visible on out_data in cycle t+1, with no combinational path in_data->out_data.
REQ-024 SHALL drive out_valid = !fifo_empty and SHALL hold out_data/out_idx/out_last stable while out_valid&&!out_ready.
REQ-025 SHALL keep in_ready low when the FIFO is full even if an output transfer occurs that cycle; simultaneous input and output transfers below full SHALL leave occupancy unchanged.
REQ-026 SHALL maintain in_cnt and out_cnt, each 0..N_ELEM, cleared on IDLE->RUN; out_idx SHALL equal out_cnt of the head word.
REQ-027 SHALL assert out_last exactly when out_valid and out_idx==N_ELEM-1.
REQ-028 SHALL accept no words after in_cnt reaches N_ELEM; surplus in_valid SHALL be ignored, not stored.

Reset
REQ-029 SHALL on rst_n=0 immediately force state=IDLE, pointers, counters and occupancy to 0, in_ready=0, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, done=0.
REQ-030 SHALL on reset mid-frame discard all buffered words; no partial frame SHALL be emitted after reset release.

Configuration
REQ-031 SHALL, with macro X_DRAIN_STATS_EN defined, add output stall_cnt (16 bits) counting RUN cycles with out_valid&&!out_ready, cleared on IDLE->RUN, saturating at 0xFFFF, reset to 0.
REQ-032 SHALL, without X_DRAIN_STATS_EN, omit the stall_cnt port and its logic entirely; all other behaviour identical.

Structure
REQ-033 SHALL place the FSM state enum and default BIT_WIDTH/N_ELEM constants in shared package gsim_pkg.
REQ-034 SHALL implement the circular buffer as sub-module x_drain_fifo (push, pop, full, empty, head data); counters and FSM SHALL stay in x_drain.

Verification
REQ-035 SHALL cover: reset, start, in_valid=1 with data 1..16 every cycle, out_ready=1 -> out_data 1..16 with out_idx 0..15, out_last on 16, done one cycle after last transfer.
REQ-036 SHALL cover: out_ready=0 for 10 cycles while feeding -> in_ready drops after 4 accepts, out_data holds 1, no word lost or duplicated after release.
REQ-037 SHALL cover: full FIFO with out_ready=1 and in_valid=1 in same cycle -> no push that cycle, push next cycle, order preserved.
REQ-038 SHALL cover: rst_n pulsed low after 7 accepted words -> all outputs 0 immediately, next frame begins at out_idx 0 with fresh data.
REQ-039 SHALL cover: start asserted during RUN and 20 in_valid words offered -> start ignored, exactly 16 accepted, one done pulse.
REQ-040 SHALL cover (X_DRAIN_STATS_EN): 5 stalled cycles in a frame -> stall_cnt=5, cleared to 0 on next start.
